sram_responder: RTL and testbench
=================================

// Module: sram_responder
// PURPOSE
//  Device-side responder for the SLC-3 external SRAM bus: answers active-low CE/OE/WE/UB/LB
//  + 20-bit ADDR from the CPU/Mem2IO side with a DEPTH x 16 on-chip array.
//  Replaces the off-chip 1Mx16 SRAM in FPGA-only builds and benches.
//  Connects to the pad tristate via split Data_write/Data_read/Data_drive.
//  Zero-fills its array after every reset (INIT), then serves reads with programmable latency.
// PARAMETERS
//  DEPTH     1024  words in array; power of 2, >=2; index = ADDR[$clog2(DEPTH)-1:0]
//  READ_LAT  1     read latency in clock edges, >=1, <=15
// PORTS
//  Clk         in   1   system clock, all state on rising edge
//  Reset       in   1   synchronous, active-high
//  CE          in   1   chip enable, active low
//  UB          in   1   upper byte lane [15:8] enable, active low
//  LB          in   1   lower byte lane [7:0] enable, active low
//  OE          in   1   output enable, active low
//  WE          in   1   write enable, active low
//  ADDR        in   20  word address; upper bits beyond index ignored (wrap mod DEPTH)
//  Data_write  in   16  data driven by CPU side on writes
//  Data_read   out  16  registered read data toward the bus
//  Data_drive  out  1   1 = responder owns the bus (tristate output enable)
//  Read_valid  out  1   Data_read holds data for the current read request
//  Ready       out  1   0 during INIT; bus accesses ignored
// BEHAVIOUR
//  Reset values: Data_read=0, Read_valid=0, Ready=0, init pointer=0, latency counter=0; FSM->INIT.
//  FSM INIT: writes 0x0000 to word[ptr], ptr++ each edge; after word DEPTH-1 -> IDLE, Ready=1.
//    INIT takes exactly DEPTH edges after the reset edge; Ready rises with the last INIT write.
//  FSM IDLE/READ: wr = ~CE & ~WE; rd = ~CE & ~OE & WE. Evaluated only when Ready=1.
//  Write: at edge with wr: word[idx][15:8]<=Data_write[15:8] if ~UB; [7:0] if ~LB. UB=LB=1: no-op.
//    Write beats OE: WE low with OE low is a write, Data_drive=0, no read started.
//  Read: IDLE->READ at first edge with rd; counter counts edges with rd and ADDR unchanged.
//    On READ_LAT-th such edge: Data_read<=word[idx] with disabled lanes forced to 0x00,
//    Read_valid<=1; stays in READ, Data_read re-sampled each edge while rd holds (tracks writes).
//    ADDR or lane change mid-latency: counter restarts at 1 from that edge, Read_valid<=0.
//    rd deasserts: Read_valid<=0 next edge, -> IDLE, Data_read holds last value.
//  Data_drive = Ready & rd (combinational from bus pins); drives even before Read_valid.
//  Write then read same word on next cycle returns the new data (no stale forwarding hazard).
//  Reset mid-operation (any state): aborts read, Read_valid=0, Ready=0, INIT restarts at word 0.
//  Accesses during INIT: writes dropped, reads give Data_drive=0, Read_valid=0.
// TESTING  (bench DEPTH=16 unless noted)
//  Reset 1 cycle -> Ready=0 for 16 edges then 1; read ADDR 0x00007 -> Data_read=0x0000.
//  READ_LAT=2: write 0x1234 @0x00005 UB=LB=0, then rd -> Read_valid after 2nd edge, 0x1234, Data_drive=1.
//  Write 0xABCD @0x00005 UB=0 LB=1 -> word=0xAB34; read UB=0 LB=1 -> Data_read=0xAB00.
//  Write 0x00FF @ADDR 0x00013 -> read ADDR 0x00003 returns 0x00FF (wrap); upper ADDR bits ignored.
//  READ_LAT=3: ADDR changes after 2 rd edges -> Read_valid only 3 edges after change, new word.
//  WE=0,OE=0 @0x00002 data 0x5555 -> Data_drive=0, word=0x5555; Reset mid-read -> Ready=0, array re-zeroed.

Source files
------------

// File: rtl/sram_responder_if.sv
// Bus bundle between the CPU/Mem2IO side (master) and the on-chip SRAM responder (slave).
// Control strobes are active low, matching the off-chip SRAM pins this replaces.
interface sram_responder_if;
  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [19:0] ADDR;
  logic [15:0] Data_write;
  logic [15:0] Data_read;
  logic        Data_drive;
  logic        Read_valid;
  logic        Ready;

  modport master (
    output CE, UB, LB, OE, WE, ADDR, Data_write,
    input  Data_read, Data_drive, Read_valid, Ready
  );

  modport slave (
    input  CE, UB, LB, OE, WE, ADDR, Data_write,
    output Data_read, Data_drive, Read_valid, Ready
  );
endinterface

// File: rtl/sram_responder.sv
// On-chip stand-in for the SLC-3 external 16-bit SRAM: zero-fills its array after reset,
// then serves byte-laned writes and reads with a programmable read latency.
module sram_responder #(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_responder_if.slave   bus
);
  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT   = 4'(READ_LAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_READ} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [19:0]       addr_q, addr_d;
  logic [1:0]        lanes_q, lanes_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;

  logic              rd;
  logic              wr;
  logic              load;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lanes;

  assign idx   = bus.ADDR[IDX_W-1:0];
  assign lanes = {~bus.UB, ~bus.LB};
  assign rd    = ~bus.CE & ~bus.OE & bus.WE;
  assign wr    = ~bus.CE & ~bus.WE;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lanes_d = lanes_q;
    valid_d = valid_q;
    ready_d = ready_q;
    load    = 1'b0;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        if (rd) begin
          state_d = ST_READ;
          addr_d  = bus.ADDR;
          lanes_d = lanes;
          // Any address or lane change restarts the latency count from this edge.
          if (state_q == ST_READ && bus.ADDR == addr_q && lanes == lanes_q)
            cnt_d = (cnt_q == LAT) ? cnt_q : cnt_q + 4'd1;
          else
            cnt_d = 4'd1;
          load    = (cnt_d == LAT);
          valid_d = load;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      cnt_q   <= 4'd0;
      addr_q  <= 20'd0;
      lanes_q <= 2'b00;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lanes_q <= lanes_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  // One byte-wide array per lane so each lane's write enable stays independent.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge Clk) begin
        if (!Reset) begin
          if (state_q == ST_INIT)
            mem[ptr_q] <= 8'h00;
          else if (wr && lanes[gi])
            mem[idx] <= bus.Data_write[gi*8 +: 8];
        end
      end

      always_ff @(posedge Clk) begin
        if (Reset)
          rd_q <= 8'h00;
        else if (load)
          rd_q <= lanes[gi] ? mem[idx] : 8'h00;
      end
    end
  endgenerate

  assign bus.Data_read  = {g_lane[1].rd_q, g_lane[0].rd_q};
  assign bus.Data_drive = ready_q & rd;
  assign bus.Read_valid = valid_q;
  assign bus.Ready      = ready_q;
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: two instances (read latency 2 and 3, DEPTH 16)
// share one stimulus stream; each scenario task checks its own expected values.
module tb_sram_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic        ce = 1'b1, ub = 1'b1, lb = 1'b1, oe = 1'b1, we = 1'b1;
  logic [19:0] addr = 20'd0;
  logic [15:0] wdata = 16'd0;

  always #5 clk = ~clk;

  sram_responder_if bus2 ();
  sram_responder_if bus3 ();

  assign bus2.CE = ce;  assign bus2.UB = ub;  assign bus2.LB = lb;
  assign bus2.OE = oe;  assign bus2.WE = we;  assign bus2.ADDR = addr;
  assign bus2.Data_write = wdata;
  assign bus3.CE = ce;  assign bus3.UB = ub;  assign bus3.LB = lb;
  assign bus3.OE = oe;  assign bus3.WE = we;  assign bus3.ADDR = addr;
  assign bus3.Data_write = wdata;

  sram_responder #(.DEPTH(16), .READ_LAT(2)) dut2 (.Clk(clk), .Reset(rst), .bus(bus2));
  sram_responder #(.DEPTH(16), .READ_LAT(3)) dut3 (.Clk(clk), .Reset(rst), .bus(bus3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ce = 1'b1; oe = 1'b1; we = 1'b1; ub = 1'b1; lb = 1'b1;
  endtask

  task automatic bus_write(input logic [19:0] a, input logic [15:0] d,
                           input logic u, input logic l);
    ce = 1'b0; oe = 1'b1; we = 1'b0; ub = u; lb = l; addr = a; wdata = d;
  endtask

  task automatic bus_read(input logic [19:0] a, input logic u, input logic l);
    ce = 1'b0; oe = 1'b0; we = 1'b1; ub = u; lb = l; addr = a;
  endtask

  task automatic test_reset();
    bus_read(20'h00007, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus2.Ready !== 1'b0 || bus2.Read_valid !== 1'b0 || bus2.Data_read !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b data=%h exp 0 0 0000",
               bus2.Ready, bus2.Read_valid, bus2.Data_read);
    end
    checks++;
    if (bus2.Data_drive !== 1'b0) begin
      errors++;
      $display("FAIL init_drive got %b exp 0", bus2.Data_drive);
    end
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (bus2.Ready !== 1'b0 || bus2.Read_valid !== 1'b0) begin
      errors++;
      $display("FAIL init_15_edges got ready=%b valid=%b exp 0 0", bus2.Ready, bus2.Read_valid);
    end
    tick();
    checks++;
    if (bus2.Ready !== 1'b1 || bus3.Ready !== 1'b1 || bus2.Data_drive !== 1'b1) begin
      errors++;
      $display("FAIL init_16_edges got ready2=%b ready3=%b drive=%b exp 1 1 1",
               bus2.Ready, bus3.Ready, bus2.Data_drive);
    end
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_read_lat1 got valid=%b exp 0", bus2.Read_valid);
    end
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b1 || bus2.Data_read !== 16'h0000) begin
      errors++;
      $display("FAIL zero_read got valid=%b data=%h exp 1 0000", bus2.Read_valid, bus2.Data_read);
    end
    bus_idle();
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b0 || bus2.Data_drive !== 1'b0) begin
      errors++;
      $display("FAIL read_release got valid=%b drive=%b exp 0 0", bus2.Read_valid, bus2.Data_drive);
    end
  endtask

  task automatic test_write_read();
    bus_write(20'h00005, 16'h1234, 1'b0, 1'b0);
    tick();
    bus_read(20'h00005, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus2.Data_drive !== 1'b1 || bus2.Read_valid !== 1'b0) begin
      errors++;
      $display("FAIL drive_before_valid got drive=%b valid=%b exp 1 0", bus2.Data_drive, bus2.Read_valid);
    end
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat2_first_edge got valid=%b exp 0", bus2.Read_valid);
    end
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b1 || bus2.Data_read !== 16'h1234) begin
      errors++;
      $display("FAIL write_then_read got valid=%b data=%h exp 1 1234", bus2.Read_valid, bus2.Data_read);
    end
    bus_idle();
    tick();
    checks++;
    if (bus2.Data_read !== 16'h1234) begin
      errors++;
      $display("FAIL data_hold got %h exp 1234", bus2.Data_read);
    end
  endtask

  task automatic test_byte_lanes();
    bus_write(20'h00005, 16'hABCD, 1'b0, 1'b1);
    tick();
    bus_read(20'h00005, 1'b0, 1'b1);
    tick();
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b1 || bus2.Data_read !== 16'hAB00) begin
      errors++;
      $display("FAIL upper_lane_read got valid=%b data=%h exp 1 ab00", bus2.Read_valid, bus2.Data_read);
    end
    lb = 1'b0;
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b0) begin
      errors++;
      $display("FAIL lane_change_restart got valid=%b exp 0", bus2.Read_valid);
    end
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b1 || bus2.Data_read !== 16'hAB34) begin
      errors++;
      $display("FAIL merged_word got valid=%b data=%h exp 1 ab34", bus2.Read_valid, bus2.Data_read);
    end
    bus_idle();
    tick();
  endtask

  task automatic test_wrap();
    bus_write(20'h00013, 16'h00FF, 1'b0, 1'b0);
    tick();
    bus_read(20'h00003, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b1 || bus2.Data_read !== 16'h00FF) begin
      errors++;
      $display("FAIL addr_wrap got valid=%b data=%h exp 1 00ff", bus2.Read_valid, bus2.Data_read);
    end
    bus_write(20'hFFFF3, 16'h7E81, 1'b0, 1'b0);
    tick();
    bus_read(20'h00003, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus2.Data_read !== 16'h7E81) begin
      errors++;
      $display("FAIL upper_addr_ignored got %h exp 7e81", bus2.Data_read);
    end
    bus_idle();
    tick();
  endtask

  task automatic test_addr_change_lat3();
    bus_write(20'h00008, 16'h0808, 1'b0, 1'b0);
    tick();
    bus_write(20'h00009, 16'h9999, 1'b0, 1'b0);
    tick();
    bus_read(20'h00008, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus3.Read_valid !== 1'b0 || bus2.Read_valid !== 1'b1 || bus2.Data_read !== 16'h0808) begin
      errors++;
      $display("FAIL lat_compare got valid3=%b valid2=%b data2=%h exp 0 1 0808",
               bus3.Read_valid, bus2.Read_valid, bus2.Data_read);
    end
    addr = 20'h00009;
    tick();
    tick();
    checks++;
    if (bus3.Read_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat3_after_change2 got valid=%b exp 0", bus3.Read_valid);
    end
    tick();
    checks++;
    if (bus3.Read_valid !== 1'b1 || bus3.Data_read !== 16'h9999) begin
      errors++;
      $display("FAIL lat3_new_word got valid=%b data=%h exp 1 9999", bus3.Read_valid, bus3.Data_read);
    end
    bus_idle();
    tick();
  endtask

  task automatic test_write_beats_oe();
    bus_write(20'h00002, 16'h5555, 1'b0, 1'b0);
    oe = 1'b0;
    #1;
    checks++;
    if (bus2.Data_drive !== 1'b0) begin
      errors++;
      $display("FAIL write_beats_oe_drive got %b exp 0", bus2.Data_drive);
    end
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_beats_oe_valid got %b exp 0", bus2.Read_valid);
    end
    bus_read(20'h00002, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b1 || bus2.Data_read !== 16'h5555) begin
      errors++;
      $display("FAIL write_beats_oe_word got valid=%b data=%h exp 1 5555", bus2.Read_valid, bus2.Data_read);
    end
  endtask

  task automatic test_reset_mid_read();
    bus_read(20'h00005, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus2.Ready !== 1'b0 || bus2.Read_valid !== 1'b0 || bus2.Data_drive !== 1'b0) begin
      errors++;
      $display("FAIL mid_read_reset got ready=%b valid=%b drive=%b exp 0 0 0",
               bus2.Ready, bus2.Read_valid, bus2.Data_drive);
    end
    bus_write(20'h00004, 16'h4444, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (bus2.Ready !== 1'b1) begin
      errors++;
      $display("FAIL reinit_ready got %b exp 1", bus2.Ready);
    end
    bus_read(20'h00002, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b1 || bus2.Data_read !== 16'h0000) begin
      errors++;
      $display("FAIL rezeroed_word got valid=%b data=%h exp 1 0000", bus2.Read_valid, bus2.Data_read);
    end
    addr = 20'h00004;
    tick();
    tick();
    checks++;
    if (bus2.Read_valid !== 1'b1 || bus2.Data_read !== 16'h0000) begin
      errors++;
      $display("FAIL init_write_dropped got valid=%b data=%h exp 1 0000", bus2.Read_valid, bus2.Data_read);
    end
    bus_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wrap();
    test_addr_change_lat3();
    test_write_beats_oe();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
